// File: rtl/video_stream_pkg.sv
// rtl/video_stream_pkg.sv - shared video stream types and frame constants
//
// Purpose: items shared between the frame source and the pixel filters.
// Contents:
//   IMG_W, IMG_H, PIX_W - default frame geometry and pixel width
//   rgb444_t            - {R[11:8], G[7:4], B[3:0]} pixel view
//   beat_t              - one stream beat {sop, eop, data}
//   state_t             - frame source states
//   fifo_ptr_inc        - modulo-3 pointer increment for the skid FIFO
package video_stream_pkg;

    localparam int IMG_W = 320;
    localparam int IMG_H = 240;
    localparam int PIX_W = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [PIX_W-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Pointers run 0,1,2,0,... for the 3-entry FIFO.
    function automatic logic [1:0] fifo_ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - 3-entry synchronous FIFO of stream beats
//
// Purpose: absorbs the one-cycle frame buffer read latency so the source can
// sustain one beat per clock and tolerate downstream backpressure.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   i_push        - write i_push_beat at this edge
//   i_push_beat   - beat to write
//   i_pop         - drop the head at this edge (caller guarantees non-empty)
//   o_count       - number of stored beats (0..3)
//   o_head        - oldest stored beat; stable while not popped
module stream_skid_fifo
    import video_stream_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_push,
    input  beat_t      i_push_beat,
    input  logic       i_pop,
    output logic [1:0] o_count,
    output beat_t      o_head
);

    beat_t      r_mem [0:2];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_beat;
                r_wr_ptr        <= fifo_ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= fifo_ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/frame_stream_source.sv
// rtl/frame_stream_source.sv - frame buffer to Avalon-ST video packet source
//
// Purpose: reads an RGB444 frame buffer in raster order and emits one packet
// of IMG_W*IMG_H pixels per frame, optionally back to back.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start                 - begins a frame when sampled in IDLE
//   continuous            - wrap to the next frame without a gap
//   busy                  - high outside IDLE
//   rd_en, rd_addr        - frame buffer read strobe and pixel address
//   rd_data               - read data, valid one cycle after rd_en
//   ready_in              - downstream ready (readyLatency 0)
//   valid_out, startofpacket_out, endofpacket_out, data_out - output beat
//   frame_done            - one-cycle pulse after each EOP transfer
module frame_stream_source #(
    parameter int IMG_W  = video_stream_pkg::IMG_W,
    parameter int IMG_H  = video_stream_pkg::IMG_H,
    parameter int PIX_W  = video_stream_pkg::PIX_W,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              continuous,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    input  logic              ready_in,
    output logic              valid_out,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [PIX_W-1:0]  data_out,
    output logic              frame_done
);
    import video_stream_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic              r_tag_sop;
    logic              r_tag_eop;
    logic              r_frame_done;

    logic              w_issue;
    logic              w_last;
    logic              w_xfer;
    logic [1:0]        w_count;
    beat_t             w_head;
    beat_t             w_push_beat;

    assign w_last = (r_addr == LAST_ADDR);
    assign w_xfer = (w_count != 2'd0) && ready_in;

    // Credit check uses only registered state, so ready_in never reaches
    // rd_en/rd_addr combinationally; at most one extra read lands after a stall.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_issue = (({1'b0, w_count} + {2'b00, r_inflight}) < 3'd3);
                if (w_issue && w_last && !continuous) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_xfer && w_head.eop) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_inflight   <= 1'b0;
            r_tag_sop    <= 1'b0;
            r_tag_eop    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_inflight   <= w_issue;
            r_frame_done <= w_xfer && w_head.eop;
            if (r_state == ST_IDLE && start) begin
                r_addr <= '0;
            end else if (w_issue) begin
                // Tags are captured at issue time and paired with rd_data
                // when it returns on the next cycle.
                r_tag_sop <= (r_addr == '0);
                r_tag_eop <= w_last;
                r_addr    <= w_last ? '0 : r_addr + 1'b1;
            end
        end
    end

    assign w_push_beat = '{sop: r_tag_sop, eop: r_tag_eop, data: rd_data};

    stream_skid_fifo u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (r_inflight),
        .i_push_beat (w_push_beat),
        .i_pop       (w_xfer),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign busy              = (r_state != ST_IDLE);
    assign rd_en             = w_issue;
    assign rd_addr           = r_addr;
    assign valid_out         = (w_count != 2'd0);
    assign startofpacket_out = w_head.sop;
    assign endofpacket_out   = w_head.eop;
    assign data_out          = w_head.data;
    assign frame_done        = r_frame_done;

endmodule
